// File: rtl/tick_ctrl.sv
// Game-tick source for the redstone core: debounced run/step buttons, a rate-selected
// free-running divider, a pause/run FSM and a wrapping count of issued ticks.

module tick_ctrl_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_press
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

    logic          acc_q, acc_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (i_level != acc_q) begin
            if (cnt_q == CNT_MAX) begin
                acc_d = i_level;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q  <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            prev_q <= acc_q;
            cnt_q  <= cnt_d;
        end
    end

    // Only the press (accepted 1->0) produces an event; release is silent.
    assign o_press = prev_q & ~acc_q;
endmodule

// state   | meaning
// PAUSED  | no free-run ticks; a step press issues exactly one tick
// RUNNING | divider advances each cycle and ticks once per selected period
module tick_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PERIOD0         = 5_000_000,
    parameter int PERIOD1         = 500_000,
    parameter int PERIOD2         = 50_000,
    parameter int PERIOD3         = 1,
    parameter int DIV_W           = 32,
    parameter int CNT_W           = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_run,
    input  logic             i_btn_step,
    input  logic [1:0]       i_rate_sel,
    output logic             o_tick,
    output logic             o_running,
    output logic [CNT_W-1:0] o_tick_count
);
    localparam logic [DIV_W-1:0] PMAX0 = DIV_W'(PERIOD0 - 1);
    localparam logic [DIV_W-1:0] PMAX1 = DIV_W'(PERIOD1 - 1);
    localparam logic [DIV_W-1:0] PMAX2 = DIV_W'(PERIOD2 - 1);
    localparam logic [DIV_W-1:0] PMAX3 = DIV_W'(PERIOD3 - 1);

    typedef enum logic {ST_PAUSED, ST_RUNNING} state_e;

    logic [1:0]       run_sync_q, step_sync_q;
    logic [1:0]       sel_s1_q, sel_s2_q;
    logic             run_ev, step_ev;
    logic [DIV_W-1:0] pmax;
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_sync_q  <= 2'b11;
            step_sync_q <= 2'b11;
            sel_s1_q    <= '0;
            sel_s2_q    <= '0;
        end else begin
            run_sync_q  <= {run_sync_q[0], i_btn_run};
            step_sync_q <= {step_sync_q[0], i_btn_step};
            sel_s1_q    <= i_rate_sel;
            sel_s2_q    <= sel_s1_q;
        end
    end

    tick_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (run_sync_q[1]),
        .o_press (run_ev)
    );

    tick_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (step_sync_q[1]),
        .o_press (step_ev)
    );

    always_comb begin
        case (sel_s2_q)
            2'd0:    pmax = PMAX0;
            2'd1:    pmax = PMAX1;
            2'd2:    pmax = PMAX2;
            default: pmax = PMAX3;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_PAUSED;
            div_q   <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_PAUSED: begin
                if (run_ev) begin
                    state_d = ST_RUNNING;
                    div_d   = '0;
                    // With P=1 the first RUNNING cycle already carries a tick.
                    tick_d  = (pmax == '0);
                end else if (step_ev) begin
                    tick_d = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (run_ev) begin
                    state_d = ST_PAUSED;
                    div_d   = '0;
                end else if (div_q >= pmax) begin
                    tick_d = 1'b1;
                    div_d  = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_PAUSED;
        endcase
        cnt_d = cnt_q + CNT_W'(tick_d);
    end

    assign o_tick       = tick_q;
    assign o_running    = (state_q == ST_RUNNING);
    assign o_tick_count = cnt_q;
endmodule

// File: tb/tb_tick_ctrl.sv
// Directed bench for tick_ctrl with short debounce and periods; inputs are driven and
// outputs sampled on the falling edge, cycle numbers are negedges after the first drive.

module tb_tick_ctrl;
    logic       clk = 1'b0;
    logic       rst, btn_run, btn_step;
    logic [1:0] sel;
    logic       tick, running;
    logic [7:0] cnt;

    int         vec  = 0;
    int         errs = 0;
    logic [7:0] exp_cnt;

    tick_ctrl #(
        .DEBOUNCE_CYCLES(4), .PERIOD0(10), .PERIOD1(5), .PERIOD2(3), .PERIOD3(1),
        .DIV_W(32), .CNT_W(8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_run    (btn_run),
        .i_btn_step   (btn_step),
        .i_rate_sel   (sel),
        .o_tick       (tick),
        .o_running    (running),
        .o_tick_count (cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; btn_run = 1'b1; btn_step = 1'b1; sel = 2'd0;
        repeat (3) @(negedge clk);
        vec++; if (tick !== 1'b0) begin errs++; $display("FAIL reset_tick: got %b expected 0", tick); end
        vec++; if (running !== 1'b0) begin errs++; $display("FAIL reset_running: got %b expected 0", running); end
        vec++; if (cnt !== 8'd0) begin errs++; $display("FAIL reset_count: got %0d expected 0", cnt); end
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_debounce;
        logic seen;
        int   n;
        btn_run = 1'b0;
        repeat (3) @(negedge clk);
        btn_run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (running === 1'b1 || tick === 1'b1) seen = 1'b1;
        end
        vec++; if (seen !== 1'b0) begin errs++; $display("FAIL glitch_reject: activity %b expected 0", seen); end
        btn_run = 1'b0;
        n = 0;
        while (n < 20 && running !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        vec++; if (n != 7) begin errs++; $display("FAIL debounce_latency: got %0d cycles expected 7", n); end
    endtask

    // Continues directly from the cycle RUNNING was first observed (k=0).
    task automatic test_free_run;
        logic et, er;
        btn_run = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            et = (k == 10 || k == 20 || k == 30);
            er = (k < 37);
            if (et) exp_cnt++;
            vec++; if (tick !== et) begin errs++; $display("FAIL free_run_tick k=%0d: got %b expected %b", k, tick, et); end
            vec++; if (running !== er) begin errs++; $display("FAIL free_run_running k=%0d: got %b expected %b", k, running, er); end
            if (k == 30) btn_run = 1'b0;
            if (k == 37) btn_run = 1'b1;
        end
        vec++; if (cnt !== 8'd3) begin errs++; $display("FAIL free_run_count: got %0d expected 3", cnt); end
    endtask

    task automatic test_step;
        logic et;
        btn_step = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            et = (c == 7);
            if (et) exp_cnt++;
            vec++; if (tick !== et) begin errs++; $display("FAIL step_tick c=%0d: got %b expected %b", c, tick, et); end
            vec++; if (running !== 1'b0) begin errs++; $display("FAIL step_running c=%0d: got %b expected 0", c, running); end
            if (c == 7) btn_step = 1'b1;
        end
        vec++; if (cnt !== 8'd4) begin errs++; $display("FAIL step_count: got %0d expected 4", cnt); end
    endtask

    task automatic test_step_while_running;
        logic et, er;
        btn_run = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            et = (c == 17 || c == 27);
            er = (c >= 7 && c < 37);
            if (et) exp_cnt++;
            vec++; if (tick !== et) begin errs++; $display("FAIL run_step_tick c=%0d: got %b expected %b", c, tick, et); end
            vec++; if (running !== er) begin errs++; $display("FAIL run_step_running c=%0d: got %b expected %b", c, running, er); end
            if (c == 7)  btn_run  = 1'b1;
            if (c == 15) btn_step = 1'b0;
            if (c == 22) btn_step = 1'b1;
            if (c == 30) btn_run  = 1'b0;
            if (c == 37) btn_run  = 1'b1;
        end
        vec++; if (cnt !== 8'd6) begin errs++; $display("FAIL run_step_count: got %0d expected 6", cnt); end
    endtask

    task automatic test_simultaneous;
        logic et, er;
        btn_run = 1'b0; btn_step = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            et = (c == 17);
            er = (c >= 7 && c < 22);
            if (et) exp_cnt++;
            vec++; if (tick !== et) begin errs++; $display("FAIL simul_tick c=%0d: got %b expected %b", c, tick, et); end
            vec++; if (running !== er) begin errs++; $display("FAIL simul_running c=%0d: got %b expected %b", c, running, er); end
            if (c == 7) begin btn_run = 1'b1; btn_step = 1'b1; end
            if (c == 15) btn_run = 1'b0;
            if (c == 22) btn_run = 1'b1;
        end
        vec++; if (cnt !== 8'd7) begin errs++; $display("FAIL simul_count: got %0d expected 7", cnt); end
    endtask

    task automatic test_rate_change;
        logic et;
        btn_run = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            et = (c == 14 || c == 17 || c == 20 || c >= 23);
            if (et) exp_cnt++;
            vec++; if (tick !== et) begin errs++; $display("FAIL rate_tick c=%0d: got %b expected %b", c, tick, et); end
            vec++; if (running !== (c >= 7)) begin errs++; $display("FAIL rate_running c=%0d: got %b", c, running); end
            if (c == 7)  btn_run = 1'b1;
            if (c == 11) sel = 2'd2;
            if (c == 20) sel = 2'd3;
        end
        vec++; if (cnt !== 8'd18) begin errs++; $display("FAIL rate_count: got %0d expected 18", cnt); end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            exp_cnt++;
            vec++; if (tick !== 1'b1) begin errs++; $display("FAIL p1_tick i=%0d: got %b expected 1", i, tick); end
            vec++; if (cnt !== exp_cnt) begin errs++; $display("FAIL p1_count i=%0d: got %0d expected %0d", i, cnt, exp_cnt); end
            if (exp_cnt == 8'd0) begin
                vec++; if (cnt !== 8'd0) begin errs++; $display("FAIL count_wrap: got %0d expected 0", cnt); end
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic et;
        sel = 2'd0;
        repeat (6) @(negedge clk);
        rst = 1'b1; btn_run = 1'b0; sel = 2'd3;
        @(negedge clk);
        vec++; if (tick !== 1'b0) begin errs++; $display("FAIL midrst_tick: got %b expected 0", tick); end
        vec++; if (running !== 1'b0) begin errs++; $display("FAIL midrst_running: got %b expected 0", running); end
        vec++; if (cnt !== 8'd0) begin errs++; $display("FAIL midrst_count: got %0d expected 0", cnt); end
        rst = 1'b0;
        exp_cnt = 8'd0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            et = (c >= 7);
            if (et) exp_cnt++;
            vec++; if (running !== et) begin errs++; $display("FAIL held_btn_running c=%0d: got %b expected %b", c, running, et); end
            vec++; if (tick !== et) begin errs++; $display("FAIL held_btn_tick c=%0d: got %b expected %b", c, tick, et); end
            vec++; if (cnt !== exp_cnt) begin errs++; $display("FAIL held_btn_count c=%0d: got %0d expected %0d", c, cnt, exp_cnt); end
        end
        btn_run = 1'b1;
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_free_run;
        test_step;
        test_step_while_running;
        test_simultaneous;
        test_rate_change;
        test_wrap;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/tick_ctrl.md
# tick_ctrl

Upstream tick source for the `redstone` simulation core. It turns the raw board push-buttons and a rate-select input into a clean, single-`i_clk`-cycle `o_tick` enable that advances the redstone model one game tick. It supports free-running at a selectable rate, pause, and single-step, and keeps a count of ticks issued. It replaces the direct PLL/divider-to-`tick` connection in the board top level. `redstone` consumes `o_tick` as a clock enable in the `i_clk` domain.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a synchronized button level must be stable before it is accepted (20 ms at 50 MHz).
- `PERIOD0`, default 5_000_000: tick period in `i_clk` cycles for `i_rate_sel`=0 (10 TPS).
- `PERIOD1`, default 500_000: period for sel=1.
- `PERIOD2`, default 50_000: period for sel=2.
- `PERIOD3`, default 1: period for sel=3 (tick every cycle).
- `DIV_W`, default 32: divider counter width. Every PERIODn must be ≥1 and < 2^DIV_W.
- `CNT_W`, default 32: width of the tick counter.

Ports:
- `i_clk` in 1: system clock (50 MHz board clock).
- `i_rst` in 1: reset. Synchronous, active-high.
- `i_btn_run` in 1: raw, asynchronous, active-low button. Each press toggles RUN/PAUSE.
- `i_btn_step` in 1: raw, asynchronous, active-low button. Each press issues one tick while paused.
- `i_rate_sel` in 2: selects PERIOD0..3. It is a quasi-static switch input, synchronized internally.
- `o_tick` out 1: one-cycle enable pulse, one per game tick.
- `o_running` out 1: high in RUNNING state.
- `o_tick_count` out CNT_W: total ticks issued since reset. Wraps modulo 2^CNT_W.

## Operation

- **Reset values.** Reset is synchronous and has priority over everything.
  - `o_tick`=0, `o_running`=0, `o_tick_count`=0.
  - FSM is in PAUSED; divider counter is 0.
  - Accepted button levels are "released" (1); debounce counters are 0.
- **Synchronizers.** Two-flop synchronizers on `i_btn_run`, `i_btn_step` and each `i_rate_sel` bit.
- **Debounce** (one instance per button):
  - The counter clears whenever the synchronized level equals the accepted level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1 while still differing, the accepted level flips on the next edge and the counter clears.
- **Press event.** A one-cycle pulse when the accepted level goes 1→0. Release produces no event.
- **FSM states:**
  - PAUSED:
    - run event → RUNNING, divider cleared to 0.
    - step event → `o_tick` pulses once.
  - RUNNING:
    - run event → PAUSED, divider cleared to 0. A partially elapsed period is discarded; no tick is emitted on exit.
    - step events are ignored.
- **Divider.** In RUNNING, the divider increments each cycle. When divider ≥ P−1 (P = currently selected period), `o_tick` pulses and the divider wraps to 0.
- **Rate change mid-period.** The new P applies immediately. If the divider is already ≥ new P−1, a tick fires on the next cycle and the divider wraps.
- **Simultaneous events.** If run and step events occur in the same cycle, the run event wins and the step is dropped.
- **Tick counter.** `o_tick_count` increments in the same cycle `o_tick` is high. From all-ones it wraps to 0.
- **Output timing.** `o_tick` and `o_running` are registered outputs; no combinational path from any input.

## Timing

- **Raw button edge to accepted level change:** DEBOUNCE_CYCLES+2 cycles, given a clean edge.
- **Accepted-level change to press event:** same cycle.
- **Event to response:** the FSM state change, or the step `o_tick` pulse, appears one cycle after the press event.
- **First free-run tick:** `o_tick` is high exactly P cycles after the first cycle with `o_running`=1. Ticks then repeat every P cycles.
- **P=1:** `o_tick` is high on every RUNNING cycle, starting with the first RUNNING cycle.
- **Pulse width:** `o_tick` is never high for more than one consecutive cycle, except when P=1.
- **Reset mid-operation:** outputs hold their reset values on the cycle after `i_rst` is sampled high. After `i_rst` falls, a button already held low needs a full debounce before its press is recognized.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, PERIOD0=10, PERIOD1=5, PERIOD2=3, PERIOD3=1, CNT_W=8.

1. **Reset.** Hold `i_rst` high for 3 cycles with buttons released → `o_tick`=0, `o_running`=0, `o_tick_count`=0.
2. **Debounce.**
   - Run button glitches low for 3 cycles, then high → no state change.
   - A clean hold low → `o_running`=1 exactly 7 cycles after the raw edge (4+2+1).
3. **Free-run.** With sel=0, RUNNING → `o_tick` pulses at cycles 10, 20, 30 after entry; `o_tick_count`=3.
4. **Step and priority.**
   - While paused, press step → exactly one `o_tick`; count increments by 1.
   - While running, step press → no extra tick.
   - Run and step presses accepted in the same cycle → toggle only, no step tick.
5. **Rate change and P=1.**
   - Running with sel=0, divider at 6; switch to sel=2 → tick on the next cycle after the synchronized change, then every 3 cycles.
   - With sel=3 → `o_tick` high continuously.
6. **Wrap and reset mid-run.**
   - Preload via 255 ticks at sel=3 → next tick gives `o_tick_count`=0.
   - Assert `i_rst` mid-period → no tick; state is PAUSED.
